sram_1w1r_wmask_pipe: RTL and testbench
=======================================

Name: sram_1w1r_wmask_pipe

Overview:
Parametrised, synthesizable single-clock 1W1R SRAM macro model. It is the successor to the fixed 64x512 OpenRAM 1w1r behavioural models.
Adds byte write mask, configurable read latency with valid strobe, defined read-during-write collision policy, and post-reset zero-initialisation.
Sits between accelerator datapaths and the SRAM macro slot; drop-in for netlist-level simulation and FPGA prototyping.

Parameters:
DATA_WIDTH, 512, data word width in bits; must be a multiple of 8.
ADDR_WIDTH, 6, address width; RAM_DEPTH = 1 << ADDR_WIDTH (derived, not overridable).
READ_LATENCY, 1, cycles from read accept to dout1_valid; legal 1..3.
COLLISION_MODE, 0, 0 = READ_FIRST (old data), 1 = WRITE_FIRST (merged new data).
INIT_ZERO, 1, 1 = zero all words after reset before accepting traffic; 0 = skip init.

Ports:
clk  input  1  single clock, all logic posedge.
rstb  input  1  asynchronous active-low reset.
csb0  input  1  write port chip select, active low.
addr0  input  ADDR_WIDTH  write address.
din0  input  DATA_WIDTH  write data.
wmask0  input  DATA_WIDTH/8  byte write enables, bit i covers din0[8i+7:8i].
csb1  input  1  read port chip select, active low.
addr1  input  ADDR_WIDTH  read address.
dout1  output  DATA_WIDTH  read data.
dout1_valid  output  1  one-cycle strobe, dout1 holds a valid read result.
collision  output  1  strobe aligned with dout1_valid; this read hit the same address as a same-cycle write.
init_done  output  1  high once memory accepts traffic.

Behaviour:
- Reset (rstb low, asynchronous): dout1=0, dout1_valid=0, collision=0, init_done=0, init counter=0, read pipeline flushed, FSM->INIT (or READY if INIT_ZERO=0). Memory array not reset directly.
- FSM INIT: each cycle writes all-zero to mem[cnt], cnt++. After writing word RAM_DEPTH-1, next state is READY. init_done rises on the first READY cycle, i.e. RAM_DEPTH cycles after reset release. csb0/csb1 ignored in INIT: no write, no read accepted, no valid.
- INIT_ZERO=0: FSM enters READY directly; init_done=1 on the first posedge after reset release.
- FSM READY: terminal until reset. Reset mid-INIT restarts the count at 0.
- Write (READY, csb0=0, posedge): for every i with wmask0[i]=1, mem[addr0][8i+:8] <= din0[8i+:8]. Unmasked bytes unchanged. wmask0=0 is a no-op.
- Read (READY, csb1=0, posedge): accepted; addr1 sampled.
  - Data appears on dout1 with dout1_valid=1 exactly READ_LATENCY cycles later.
  - Back-to-back reads every cycle are supported; pipeline holds up to READ_LATENCY reads in flight.
- dout1 holds its last value when dout1_valid=0; it never goes X.
- Collision (same-cycle accepted read and write, addr0==addr1):
  - READ_FIRST: returns the pre-write word.
  - WRITE_FIRST: returns masked bytes from din0 and other bytes from the old word.
  - collision=1 together with that read's dout1_valid, in both modes.
- Write in cycle N, read of the same address in cycle N+1 or later: always returns the new data, independent of mode.
- Address wrap: addresses are full-range (power-of-two depth); no out-of-range case.
- Parameter checks: an elaboration-time error is raised for DATA_WIDTH%8!=0 or READ_LATENCY outside 1..3.

Decomposition:
- Package sram_pkg:
  - collision mode constants READ_FIRST/WRITE_FIRST.
  - FSM state enum INIT/READY.
  - helper function for byte-mask merge (old, new, mask) -> word.
- Sub-module sram_rd_pipe: parametrised valid/data/collision shift pipeline of depth READ_LATENCY-1 after the array read register, with async reset of the valid bits.
- Array, write logic and FSM stay in the top module.

Test Plan:
- Init: release rstb, DEPTH=64, INIT_ZERO=1 -> init_done rises at cycle 64; csb1=0 addr1=5 during init gives no dout1_valid; a read after init returns 0.
- Masked write: write addr0=3, din0=all 0xAA, wmask0=all 1; then write din0=all 0x55, wmask0 with only bit 0 set; read addr1=3 -> byte0=0x55, all other bytes 0xAA.
- Latency: READ_LATENCY=3, reads of addr 1,2,3 in consecutive cycles -> dout1_valid high in cycles +3,+4,+5 with the matching data; dout1 stable afterwards.
- Collision: mem[7]=0x11 pattern, same-cycle write 0x22 (full mask) and read of addr 7 -> READ_FIRST returns 0x11 pattern, WRITE_FIRST returns 0x22 pattern; collision=1 with valid in both.
- Reset mid-operation: assert rstb low with 2 reads in flight at cycle 10 of init restart -> valid drops immediately, init_done=0, init restarts; no stale valid after release.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants and helpers for the parametrised 1W1R SRAM model.
package sram_pkg;

    localparam int unsigned READ_FIRST  = 0;
    localparam int unsigned WRITE_FIRST = 1;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Byte-lane merge: take the new byte when its write enable is set.
    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-result delay line placed after the array read register.
module sram_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned DEPTH      = 0
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  in_valid,
    input  logic                  in_coll,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic                  out_coll,
    output logic [DATA_WIDTH-1:0] out_data
);

    if (DEPTH == 0) begin : g_bypass
        assign out_valid = in_valid;
        assign out_coll  = in_coll;
        assign out_data  = in_data;
    end else begin : g_stages
        logic [DEPTH-1:0]      valid_q;
        logic [DEPTH-1:0]      coll_q;
        logic [DATA_WIDTH-1:0] data_q [DEPTH];

        // Data only advances with a valid beat so every stage holds its last result.
        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                valid_q <= '0;
                coll_q  <= '0;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                valid_q[0] <= in_valid;
                coll_q[0]  <= in_coll;
                if (in_valid) begin
                    data_q[0] <= in_data;
                end
                for (int i = 1; i < int'(DEPTH); i++) begin
                    valid_q[i] <= valid_q[i-1];
                    coll_q[i]  <= coll_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end

        assign out_valid = valid_q[DEPTH-1];
        assign out_coll  = coll_q[DEPTH-1];
        assign out_data  = data_q[DEPTH-1];
    end

endmodule

// File: rtl/sram_1w1r_wmask_pipe.sv
// 1W1R SRAM model with byte write mask, pipelined read, collision policy
// and post-reset zero fill.
module sram_1w1r_wmask_pipe
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 512,
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned COLLISION_MODE = READ_FIRST,
    parameter int unsigned INIT_ZERO      = 1
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    csb0,
    input  logic [ADDR_WIDTH-1:0]   addr0,
    input  logic [DATA_WIDTH-1:0]   din0,
    input  logic [DATA_WIDTH/8-1:0] wmask0,
    input  logic                    csb1,
    input  logic [ADDR_WIDTH-1:0]   addr1,
    output logic [DATA_WIDTH-1:0]   dout1,
    output logic                    dout1_valid,
    output logic                    collision,
    output logic                    init_done
);

    localparam int unsigned RAM_DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned NUM_BYTES   = DATA_WIDTH / 8;
    localparam logic [0:0]  RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_READY;

    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("sram_1w1r_wmask_pipe: DATA_WIDTH must be a multiple of 8");
    end
    if ((READ_LATENCY < 1) || (READ_LATENCY > 3)) begin : g_bad_latency
        $error("sram_1w1r_wmask_pipe: READ_LATENCY must be in 1..3");
    end

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  init_wr_c;
    logic                  wr_en_c, rd_en_c, hit_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic                  rd_valid_q, rd_coll_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Zero-fill walks every word once, then parks in READY until reset.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_wr_c = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_wr_c = 1'b1;
                cnt_d     = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == '1) begin
                    state_d = ST_READY;
                end
            end
            default: ;
        endcase
        init_done_d = (state_d == ST_READY);
    end

    assign wr_en_c = init_done_q & ~csb0;
    assign rd_en_c = init_done_q & ~csb1;

    always_ff @(posedge clk) begin
        if (init_wr_c) begin
            mem[cnt_q] <= '0;
        end else if (wr_en_c) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                if (wmask0[i]) begin
                    mem[addr0][8*i +: 8] <= din0[8*i +: 8];
                end
            end
        end
    end

    // Array read with same-cycle write forwarding when WRITE_FIRST.
    always_comb begin
        hit_c     = rd_en_c & wr_en_c & (addr0 == addr1);
        rd_word_c = mem[addr1];
        if ((COLLISION_MODE == WRITE_FIRST) && hit_c) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                rd_word_c[8*i +: 8] = merge_byte(rd_word_c[8*i +: 8], din0[8*i +: 8], wmask0[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_valid_q <= 1'b0;
            rd_coll_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en_c;
            rd_coll_q  <= hit_c;
            if (rd_en_c) begin
                rd_data_q <= rd_word_c;
            end
        end
    end

    sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (READ_LATENCY - 1)
    ) u_rd_pipe (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (rd_valid_q),
        .in_coll   (rd_coll_q),
        .in_data   (rd_data_q),
        .out_valid (dout1_valid),
        .out_coll  (collision),
        .out_data  (dout1)
    );

    assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_1w1r_wmask_pipe.sv
// Bench: two instances (latency 3 / READ_FIRST, latency 1 / WRITE_FIRST) against a word-level model.
module tb_sram_1w1r_wmask_pipe;

    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT_A = 3;

    typedef struct packed {
        logic          v;
        logic          c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rstb;
    logic          csb0, csb1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0;
    logic [7:0]    wmask0;
    logic [DW-1:0] dout_a, dout_b;
    logic          valid_a, valid_b, coll_a, coll_b, done_a, done_b;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem_m [DEPTH];
    ent_t          qa[$];
    ent_t          qb[$];
    ent_t          cur_a, cur_b;
    logic [DW-1:0] hold_a, hold_b;
    int            edges;

    always #5 clk = ~clk;

    sram_1w1r_wmask_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT_A),
        .COLLISION_MODE(0), .INIT_ZERO(1)
    ) dut_a (
        .clk(clk), .rstb(rstb), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
        .csb1(csb1), .addr1(addr1), .dout1(dout_a), .dout1_valid(valid_a),
        .collision(coll_a), .init_done(done_a)
    );

    sram_1w1r_wmask_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
        .COLLISION_MODE(1), .INIT_ZERO(1)
    ) dut_b (
        .clk(clk), .rstb(rstb), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
        .csb1(csb1), .addr1(addr1), .dout1(dout_b), .dout1_valid(valid_b),
        .collision(coll_b), .init_done(done_b)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [7:0] m);
        logic [DW-1:0] bm;
        for (int i = 0; i < 8; i++) bm[8*i +: 8] = {8{m[i]}};
        return (o & ~bm) | (n & bm);
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic init_exp;
        init_exp = (edges >= DEPTH);
        check("a_valid", DW'(valid_a), DW'(cur_a.v));
        check("a_coll",  DW'(coll_a),  DW'(cur_a.v & cur_a.c));
        check("a_dout",  dout_a, hold_a);
        check("a_init",  DW'(done_a),  DW'(init_exp));
        check("b_valid", DW'(valid_b), DW'(cur_b.v));
        check("b_coll",  DW'(coll_b),  DW'(cur_b.v & cur_b.c));
        check("b_dout",  dout_b, hold_b);
        check("b_init",  DW'(done_b),  DW'(init_exp));
    endtask

    task automatic apply_reset();
        rstb = 1'b0;
        #1;
        edges = 0;
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
        qa.delete();
        qb.delete();
        for (int i = 0; i < int'(LAT_A) - 1; i++) qa.push_back('0);
        cur_a  = '0;
        cur_b  = '0;
        hold_a = '0;
        hold_b = '0;
        check_all();
    endtask

    task automatic tick();
        logic          rd, wr, hit;
        logic [DW-1:0] old_w;
        @(posedge clk);
        if (rstb) begin
            rd    = (edges >= DEPTH) && !csb1;
            wr    = (edges >= DEPTH) && !csb0;
            old_w = mem_m[addr1];
            hit   = rd && wr && (addr0 == addr1);
            qa.push_back({rd, hit, old_w});
            qb.push_back({rd, hit, hit ? merge(old_w, din0, wmask0) : old_w});
            if (wr) mem_m[addr0] = merge(mem_m[addr0], din0, wmask0);
            edges++;
            cur_a = qa.pop_front();
            cur_b = qb.pop_front();
            if (cur_a.v) hold_a = cur_a.d;
            if (cur_b.v) hold_b = cur_b.d;
        end
        #1;
        check_all();
    endtask

    task automatic drive(input logic c0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic [7:0] m0, input logic c1, input logic [AW-1:0] a1);
        csb0 = c0; addr0 = a0; din0 = d0; wmask0 = m0; csb1 = c1; addr1 = a1;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, '0, '0, '0, 1'b1, '0);
    endtask

    task automatic run_init(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, AW'($urandom), {$urandom, $urandom}, 8'hFF, 1'b0, AW'(5));
    endtask

    initial begin
        rstb = 1'b1; csb0 = 1'b1; csb1 = 1'b1;
        addr0 = '0; addr1 = '0; din0 = '0; wmask0 = '0;
        #2;
        apply_reset();
        tick();
        rstb = 1'b1;

        // Zero fill: traffic offered during init must be ignored.
        run_init(DEPTH);
        drive(1'b1, '0, '0, '0, 1'b0, AW'(5));
        idle(4);

        // Byte-masked write then readback.
        drive(1'b0, AW'(3), {8{8'hAA}}, 8'hFF, 1'b1, '0);
        drive(1'b0, AW'(3), {8{8'h55}}, 8'h01, 1'b1, '0);
        drive(1'b0, AW'(4), {8{8'h77}}, 8'h00, 1'b0, AW'(3));
        drive(1'b1, '0, '0, '0, 1'b0, AW'(4));
        idle(4);

        // Back-to-back reads.
        for (int i = 1; i <= 3; i++)
            drive(1'b0, AW'(i), {$urandom, $urandom}, 8'hFF, 1'b1, '0);
        for (int i = 1; i <= 3; i++)
            drive(1'b1, '0, '0, '0, 1'b0, AW'(i));
        idle(6);

        // Same-cycle collisions, full then partial mask.
        drive(1'b0, AW'(7), {8{8'h11}}, 8'hFF, 1'b1, '0);
        drive(1'b0, AW'(7), {8{8'h22}}, 8'hFF, 1'b0, AW'(7));
        drive(1'b0, AW'(7), {8{8'h33}}, 8'h5A, 1'b0, AW'(7));
        idle(4);

        // Randomised traffic over a narrow address window.
        for (int i = 0; i < 300; i++)
            drive(1'($urandom), AW'($urandom_range(0, 7)), {$urandom, $urandom},
                  8'($urandom), 1'($urandom), AW'($urandom_range(0, 7)));

        // Reset with reads in flight, then again part-way through init.
        drive(1'b1, '0, '0, '0, 1'b0, AW'(1));
        drive(1'b1, '0, '0, '0, 1'b0, AW'(2));
        apply_reset();
        #2 rstb = 1'b1;
        run_init(10);
        apply_reset();
        tick();
        rstb = 1'b1;
        run_init(DEPTH);
        for (int i = 0; i < 40; i++)
            drive(1'($urandom), AW'($urandom), {$urandom, $urandom},
                  8'($urandom), 1'($urandom), AW'($urandom_range(0, 7)));
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
